// File: rtl/fft_serializer.sv
// rtl/fft_serializer.sv - parallel-to-serial output stage for one FFT result frame
// Captures a frame of complex words and streams it MSB-first under valid/ready.
module fft_serializer #(
    parameter int DATA_SIZE  = 16,
    parameter int ARRAY_SIZE = 256,
    parameter int WORD_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  real_mode,
    input  logic [ARRAY_SIZE-1:0] in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_SIZE-1:0]  out,
    output logic                  out_last
);

    localparam int N_CPLX = ARRAY_SIZE / DATA_SIZE;
    localparam int N_REAL = ARRAY_SIZE / (2 * DATA_SIZE);
    localparam int CPW_C  = WORD_SIZE / DATA_SIZE;
    localparam int CPW_R  = WORD_SIZE / (2 * DATA_SIZE);
    localparam int CW     = (N_CPLX > 1) ? $clog2(N_CPLX) : 1;

    localparam logic [CW-1:0] LAST_CPLX = CW'(N_CPLX - 1);
    localparam logic [CW-1:0] LAST_REAL = CW'(N_REAL - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state;
    logic [ARRAY_SIZE-1:0] frame;
    logic                  mode;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;

    assign cnt_next = cnt + CW'(1);

    function automatic logic [CW-1:0] last_of(input logic m);
        return m ? LAST_REAL : LAST_CPLX;
    endfunction

    // Chunk idx of word k sits DATA_SIZE*(j+1) below the top of that word;
    // real mode only walks the upper half of each word.
    function automatic logic [DATA_SIZE-1:0] chunk_of(input logic [ARRAY_SIZE-1:0] f,
                                                      input logic m,
                                                      input logic [CW-1:0] idx);
        int k;
        int j;
        int base;
        logic [ARRAY_SIZE-1:0] sh;
        if (m) begin
            k = int'(idx) / CPW_R;
            j = int'(idx) % CPW_R;
        end else begin
            k = int'(idx) / CPW_C;
            j = int'(idx) % CPW_C;
        end
        base = WORD_SIZE * k + WORD_SIZE - DATA_SIZE * (j + 1);
        sh   = f >> base;
        return sh[DATA_SIZE-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            frame      <= '0;
            mode       <= 1'b0;
            cnt        <= '0;
            load_ready <= 1'b1;
            out_valid  <= 1'b0;
            out        <= '0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_last <= 1'b0;
                    if (load_valid) begin
                        frame      <= in;
                        mode       <= real_mode;
                        cnt        <= '0;
                        out        <= chunk_of(in, real_mode, '0);
                        out_last   <= (last_of(real_mode) == '0);
                        out_valid  <= 1'b1;
                        load_ready <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (cnt == last_of(mode)) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            load_ready <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cnt      <= cnt_next;
                            out      <= chunk_of(frame, mode, cnt_next);
                            out_last <= (cnt_next == last_of(mode));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_serializer.sv
// tb/tb_fft_serializer.sv - directed table-driven bench for fft_serializer
module tb_fft_serializer;

    logic         clk;
    logic         reset_n;
    logic         load_valid;
    logic         load_ready;
    logic         real_mode;
    logic [255:0] in;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out;
    logic         out_last;

    int total;
    int bad;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } vec_t;

    vec_t         tab [16];
    int           tab_n;
    logic [255:0] base_frame;
    logic [255:0] other_frame;
    logic [15:0]  samp [16];

    fft_serializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .real_mode  (real_mode),
        .in         (in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [255:0] f, input logic m);
        @(negedge clk);
        load_valid = 1'b1;
        in         = f;
        real_mode  = m;
        @(negedge clk);
        load_valid = 1'b0;
        in         = '0;
        real_mode  = 1'b0;
    endtask

    task automatic fill_table(input logic m);
        tab_n = m ? 8 : 16;
        for (int i = 0; i < 16; i++) begin
            if (m) tab[i].data = 16'(16'h1000 + i);
            else   tab[i].data = (i % 2 == 0) ? 16'(16'h1000 + i / 2) : 16'(16'h2000 + i / 2);
            tab[i].last = (i == tab_n - 1);
        end
    endtask

    // Expects to be entered on the negedge right after the capture edge.
    task automatic run_frame(input string name, input int stall_at);
        for (int i = 0; i < tab_n; i++) begin
            check({name, " valid"}, {31'd0, out_valid}, 32'd1);
            check({name, " data"}, {16'd0, out}, {16'd0, tab[i].data});
            check({name, " last"}, {31'd0, out_last}, {31'd0, tab[i].last});
            if (i == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    out_ready  = 1'b0;
                    load_valid = (s == 0);
                    in         = other_frame;
                    real_mode  = 1'b1;
                    @(negedge clk);
                    load_valid = 1'b0;
                    check({name, " stall data"}, {16'd0, out}, {16'd0, tab[i].data});
                    check({name, " stall valid"}, {31'd0, out_valid}, 32'd1);
                    check({name, " stall last"}, {31'd0, out_last}, 32'd0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check({name, " end valid"}, {31'd0, out_valid}, 32'd0);
        check({name, " end ready"}, {31'd0, load_ready}, 32'd1);
        check({name, " end last"}, {31'd0, out_last}, 32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        real_mode  = 1'b0;
        in         = '0;
        out_ready  = 1'b1;

        for (int k = 0; k < 8; k++) begin
            base_frame[32*k +: 32]  = {16'(16'h1000 + k), 16'(16'h2000 + k)};
            other_frame[32*k +: 32] = {16'(16'hA000 + k), 16'(16'hB000 + k)};
        end

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst load_ready", {31'd0, load_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out", {16'd0, out}, 32'd0);
        check("rst out_last", {31'd0, out_last}, 32'd0);

        fill_table(1'b0);
        load(base_frame, 1'b0);
        run_frame("cplx", -1);
        check("idle hold out", {16'd0, out}, 32'h2007);

        fill_table(1'b1);
        load(base_frame, 1'b1);
        run_frame("real", -1);

        fill_table(1'b0);
        load(base_frame, 1'b0);
        run_frame("bp", 5);

        // reset while chunk 6 is on the output
        load(base_frame, 1'b0);
        repeat (6) @(negedge clk);
        check("pre-rst chunk6", {16'd0, out}, 32'h1003);
        reset_n = 1'b0;
        #1;
        check("mid-rst valid", {31'd0, out_valid}, 32'd0);
        check("mid-rst out", {16'd0, out}, 32'd0);
        check("mid-rst ready", {31'd0, load_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        fill_table(1'b0);
        load(base_frame, 1'b0);
        run_frame("post-rst", -1);

        // round trip of random samples packed as the deserializer would
        for (int i = 0; i < 16; i++) samp[i] = 16'($urandom);
        for (int k = 0; k < 8; k++) begin
            in = '0;
            base_frame[32*k +: 32] = {samp[2*k], samp[2*k+1]};
        end
        tab_n = 16;
        for (int i = 0; i < 16; i++) begin
            tab[i].data = samp[i];
            tab[i].last = (i == 15);
        end
        load(base_frame, 1'b0);
        run_frame("rt cplx", -1);

        for (int k = 0; k < 8; k++) base_frame[32*k +: 32] = {samp[k], 16'h0000};
        tab_n = 8;
        for (int i = 0; i < 8; i++) begin
            tab[i].data = samp[i];
            tab[i].last = (i == 7);
        end
        load(base_frame, 1'b1);
        run_frame("rt real", -1);

        tab_n = 16;
        for (int i = 0; i < 16; i++) begin
            tab[i].data = (i % 2 == 0) ? samp[i/2] : 16'h0000;
            tab[i].last = (i == 15);
        end
        load(base_frame, 1'b0);
        run_frame("rt zero-imag", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_serializer.md
# fft_serializer

Parallel-to-serial output stage for the 8-point FFT datapath. Accepts one full frame of complex results as a single wide array, then streams it out DATA_SIZE bits at a time under a valid/ready handshake. Array layout matches what `deserializer` produces at the FFT input, so the two blocks round-trip bit-exactly. In real mode only the real half of each complex word is emitted.

## Interface
- DATA_SIZE, 16, serial output width; must divide WORD_SIZE/2
- ARRAY_SIZE, 256, parallel input width; multiple of WORD_SIZE
- WORD_SIZE, 32, one complex word; real = upper WORD_SIZE/2 bits, imag = lower WORD_SIZE/2 bits
- clk  input  1  clock; all state on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- load_valid  input  1  `in` and `real_mode` valid for capture
- load_ready  output  1  block can accept a frame; registered
- real_mode  input  1  sampled with the frame; 1 = emit real parts only, 0 = emit real and imag
- in  input  ARRAY_SIZE  frame; word k occupies bits [WORD_SIZE*k+WORD_SIZE-1 : WORD_SIZE*k]
- out_valid  output  1  `out` holds a valid chunk
- out_ready  input  1  downstream accepts the chunk this cycle
- out  output  DATA_SIZE  serial chunk
- out_last  output  1  high with the final chunk of a frame

## Operation
- Two states: IDLE (load_ready=1, out_valid=0) and SEND (load_ready=0, out_valid=1).
- IDLE: on load_valid=1, capture `in` into a frame register and `real_mode` into a mode flag, clear the chunk counter, and go to SEND.
- Chunks per frame: N_CPLX = ARRAY_SIZE/DATA_SIZE (16 at defaults); N_REAL = ARRAY_SIZE/(2*DATA_SIZE) (8 at defaults).
- Emission order: word 0 first, then ascending word index. Within a word, MSB-first: real part from bit WORD_SIZE*k+WORD_SIZE-1 down, then (complex mode only) imag part from bit WORD_SIZE*k+WORD_SIZE/2-1 down. Each chunk is DATA_SIZE bits taken MSB-first.
- SEND: a transfer occurs when out_valid && out_ready. On a transfer, load the next chunk into `out`. If the transferred chunk was the last one, go to IDLE instead.
- While out_valid=1 and out_ready=0, `out`, `out_last`, and the counter stay stable.
- out_last = 1 only while the final chunk (index N-1) is presented.
- load_valid during SEND is ignored. The frame is not captured and the current frame is not disturbed.
- `in` and `real_mode` are don't-care except in the capture cycle. The latched mode governs the whole frame.
- IDLE: `out` holds its last value; out_last = 0.

## Timing
- Reset values: load_ready=1, out_valid=0, out=0, out_last=0, state IDLE, counter 0, frame register 0.
- Reset asserted mid-frame: outputs take their reset values immediately and the frame is discarded. After release, the block is in IDLE.
- Capture edge t: out_valid=1 and chunk 0 on `out` from t+1.
- With out_ready held high, chunk i is presented in cycle t+1+i. The last chunk transfers at t+N. At t+N+1: out_valid=0, load_ready=1.
- Minimum frame spacing is N+1 cycles: one IDLE bubble between frames. Back-to-back loads without that bubble are not supported.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset values: hold reset_n low, then release -> load_ready=1, out_valid=0, out=0, out_last=0.
- Complex frame: word k real=16'h1000+k, imag=16'h2000+k; real_mode=0; out_ready=1 -> `out` sequence 1000,2000,1001,2001,...,1007,2007 on 16 consecutive cycles, out_last only on 2007, load_ready=1 on the following cycle.
- Real frame: same data, real_mode=1 -> 1000..1007 over 8 cycles, out_last on 1007, no imag chunks.
- Backpressure: complex frame, out_ready=0 for 3 cycles while chunk 5 (16'h2002) is shown -> `out`=2002 held stable with out_valid=1; stream then resumes with 1003. Also pulse load_valid with a different frame during SEND -> ignored, original frame completes unchanged.
- Reset mid-frame: assert reset_n low after chunk 6 -> out_valid=0 and out=0 immediately; after release, a new frame streams correctly from chunk 0.
- Round trip: drive random 16-bit samples through `deserializer` in both real_mode values and feed its `out` to this block -> serial output equals the original samples in order, with zero imag chunks in complex mode following real-mode deserialization.
